jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous mod-N up/down counter whose state bits are a bank of JK flip-flops.
- Sits directly upstream of the JK flip-flop stage: it generates the per-bit J/K excitation that drives each JK cell.
- It also holds a behavioural copy of the JK bank, so the block is self-contained and checkable.
- Used as the sequencing element for the flip-flop exercises: counters, dividers and terminal-count strobes.

Parameters:
- WIDTH, 4, number of JK state bits.
- MODULUS, 10, count range 0..MODULUS-1; legal values 2..2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset, sampled on rising clk.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load request.
- din  input  WIDTH  load value.
- q  output  WIDTH  counter state (JK bank outputs).
- qb  output  WIDTH  bitwise complement of q, always ~q.
- j_exc  output  WIDTH  J excitation for the next edge (combinational).
- k_exc  output  WIDTH  K excitation for the next edge (combinational).
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse on modulus wrap.
- load_err  output  1  registered one-cycle pulse on an out-of-range load.

Behaviour:
- Reset (rst=0 at a rising edge):
  - q=0, qb=all ones, wrap=0, load_err=0.
  - Reset has highest priority and works at any time, including mid-count or during load.
- Priority after reset: load > en > hold.
- Target next state T, computed each cycle:
  - load=1 and din<MODULUS: T=din.
  - load=1 and din>=MODULUS: T=MODULUS-1 (saturate), and load_err=1 on the next cycle.
  - en=1, up=1: T=q+1, or 0 if q==MODULUS-1.
  - en=1, up=0: T=q-1, or MODULUS-1 if q==0.
  - Otherwise: T=q.
- Excitation per bit i (fully specified, no don't-cares):
  - q[i]=0, T[i]=1: j=1, k=0.
  - q[i]=1, T[i]=0: j=0, k=1.
  - T[i]==q[i]: j=0, k=0.
- State update: q[i] <= (j_exc[i] & ~q[i]) | (~k_exc[i] & q[i]). This is the JK characteristic equation; the RTL must use this form, not assign T directly.
- tc = (up & q==MODULUS-1) | (~up & q==0).
  - Independent of en.
  - Asserted when load is active if the condition holds.
- wrap:
  - Goes to 1 for exactly one cycle after an edge where en=1, load=0 and tc=1 (a modulus wrap occurred).
  - 0 otherwise.
  - A load never produces wrap.
- load_err: 1 for exactly one cycle after an edge that performed a saturated load; 0 otherwise.
- Latency:
  - q changes one clk after the qualifying inputs.
  - j_exc, k_exc and tc respond combinationally to inputs and q.
- Direction change mid-count takes effect on the next edge with no skipped or repeated state.
- Simultaneous load and en: the load wins, the count is ignored, and wrap=0.
- State q>=MODULUS is unreachable. There is no recovery logic beyond reset/load.
- MODULUS=2^WIDTH: wrap coincides with natural binary rollover, and load_err can never assert.

Test Plan:
- Reset: rst=0 for 2 cycles with en=1, up=1 -> q=0, qb=4'hF, wrap=0, load_err=0. Release and count 3 edges -> q=3.
- Up wrap (WIDTH=4, MODULUS=10): en=1, up=1 from 0 for 10 edges -> q runs 0..9, then 0.
  - tc=1 only while q=9.
  - wrap=1 exactly in the cycle after 9->0.
  - At q=9: j_exc=4'b0000, k_exc=4'b1001.
- Down wrap: load din=0, then en=1, up=0 -> q=9, 8, 7.
  - tc=1 while q=0; wrap pulses once after 0->9.
  - At q=0: j_exc=4'b1001, k_exc=0.
- Load priority and saturation:
  - load=1, en=1, din=5 -> q=5, wrap=0.
  - load=1, din=12 -> q=9, load_err=1 for one cycle.
  - load=1 with din=9 at q=9 (tc=1) -> wrap stays 0.
- Hold and direction flip:
  - en=0 for 5 cycles at q=7 -> q=7, j_exc=k_exc=0.
  - Then up toggles 1->0 between edges -> q goes 8, then 7, then 6.
- Reset mid-operation: rst=0 asserted on the same edge as load=1, din=3 -> q=0, and load_err and wrap are 0 the following cycle.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter built on a JK flip-flop bank.
// Emits per-bit J/K excitation plus tc, wrap and load_err strobes.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   en       count enable
//   up       direction, 1 = up, 0 = down
//   load     parallel load request (wins over en)
//   din      load value; values >= MODULUS saturate to MODULUS-1
//   q, qb    JK bank outputs and their complement
//   j_exc    J excitation for the next edge
//   k_exc    K excitation for the next edge
//   tc       terminal count for the current direction
//   wrap     one-cycle pulse after a counting wrap
//   load_err one-cycle pulse after a saturated load
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] j_exc,
    output logic [WIDTH-1:0] k_exc,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2^WIDTH is representable.
    localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_next;
    logic             at_max;
    logic             at_zero;
    logic             din_ok;
    logic             sat;

    assign at_max  = (q == MAXV);
    assign at_zero = (q == '0);
    assign din_ok  = ({1'b0, din} < MODW);

    always_comb begin
        t   = q;
        sat = 1'b0;
        if (load) begin
            if (din_ok) begin
                t = din;
            end else begin
                t   = MAXV;
                sat = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                t = at_max ? '0 : q + 1'b1;
            end else begin
                t = at_zero ? MAXV : q - 1'b1;
            end
        end
    end

    // Fully specified excitation: set on 0->1, reset on 1->0, hold else.
    assign j_exc = t & ~q;
    assign k_exc = ~t & q;

    // JK characteristic equation drives the bank.
    assign q_next = (j_exc & ~q) | (~k_exc & q);

    assign tc = (up & at_max) | (~up & at_zero);
    assign qb = ~q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next;
            wrap     <= en & ~load & tc;
            load_err <= sat;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10).
// Driver queues hand-computed expectations; monitor checks each cycle.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] j_exc;
    logic [3:0] k_exc;
    logic       tc;
    logic       wrap;
    logic       load_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] q;
        logic       wrap;
        logic       lerr;
        logic       ct;
        logic       tc;
        logic       cj;
        logic [3:0] j;
        logic [3:0] k;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .din      (din),
        .q        (q),
        .qb       (qb),
        .j_exc    (j_exc),
        .k_exc    (k_exc),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id,
                       input logic [3:0] a, input logic [3:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, a, e);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] d,
                       input logic [3:0] eq, input logic ew,
                       input logic el);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        up   = u;
        load = l;
        din  = d;
        x.q    = eq;
        x.wrap = ew;
        x.lerr = el;
        x.ct   = 1'b0;
        x.tc   = 1'b0;
        x.cj   = 1'b0;
        x.j    = 4'h0;
        x.k    = 4'h0;
        x.id   = vec;
        vec++;
        sb.push_back(x);
    endtask

    // Add combinational expectations to the most recently queued item.
    task automatic expc(input logic ct, input logic et,
                        input logic cj, input logic [3:0] ej,
                        input logic [3:0] ek);
        int n;
        n = sb.size() - 1;
        sb[n].ct = ct;
        sb[n].tc = et;
        sb[n].cj = cj;
        sb[n].j  = ej;
        sb[n].k  = ek;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("q", x.id, q, x.q);
            chk("qb", x.id, qb, ~x.q);
            chk("wrap", x.id, {3'b0, wrap}, {3'b0, x.wrap});
            chk("load_err", x.id, {3'b0, load_err}, {3'b0, x.lerr});
            if (x.ct) chk("tc", x.id, {3'b0, tc}, {3'b0, x.tc});
            if (x.cj) begin
                chk("j_exc", x.id, j_exc, x.j);
                chk("k_exc", x.id, k_exc, x.k);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        load = 1'b0;
        din  = 4'h0;

        // Reset held two cycles while counting is requested
        cyc(0, 1, 1, 0, 4'd0, 4'd0, 0, 0);
        expc(1, 0, 1, 4'h1, 4'h0);
        cyc(0, 1, 1, 0, 4'd0, 4'd0, 0, 0);
        cyc(1, 1, 1, 0, 4'd0, 4'd1, 0, 0);
        cyc(1, 1, 1, 0, 4'd0, 4'd2, 0, 0);
        cyc(1, 1, 1, 0, 4'd0, 4'd3, 0, 0);

        // Up count 0..9 and wrap to 0
        cyc(1, 0, 1, 1, 4'd0, 4'd0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 1, 1, 0, 4'd0, 4'(i % 10), (i == 10), 0);
            expc(1, (i == 9), 0, 4'h0, 4'h0);
            if (i == 9) expc(1, 1, 1, 4'b0000, 4'b1001);
        end
        cyc(1, 0, 1, 0, 4'd0, 4'd0, 0, 0);

        // Down count through 0 -> 9
        cyc(1, 0, 0, 1, 4'd2, 4'd2, 0, 0);
        cyc(1, 1, 0, 0, 4'd0, 4'd1, 0, 0);
        expc(1, 0, 0, 4'h0, 4'h0);
        cyc(1, 1, 0, 0, 4'd0, 4'd0, 0, 0);
        expc(1, 1, 1, 4'b1001, 4'b0000);
        cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 0);
        expc(1, 0, 1, 4'b0000, 4'b0001);
        cyc(1, 1, 0, 0, 4'd0, 4'd8, 0, 0);
        cyc(1, 1, 0, 0, 4'd0, 4'd7, 0, 0);

        // Load priority and saturation
        cyc(1, 1, 1, 1, 4'd5, 4'd5, 0, 0);
        cyc(1, 0, 1, 1, 4'd12, 4'd9, 0, 1);
        cyc(1, 0, 1, 0, 4'd0, 4'd9, 0, 0);
        cyc(1, 1, 1, 1, 4'd9, 4'd9, 0, 0);
        expc(1, 1, 1, 4'h0, 4'h0);
        cyc(1, 0, 1, 0, 4'd0, 4'd9, 0, 0);
        cyc(1, 0, 1, 1, 4'd10, 4'd9, 0, 1);
        cyc(1, 0, 1, 1, 4'd15, 4'd9, 0, 1);
        cyc(1, 0, 1, 1, 4'd0, 4'd0, 0, 0);

        // Hold at 7, then direction flip
        cyc(1, 0, 1, 1, 4'd7, 4'd7, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 0, 4'd0, 4'd7, 0, 0);
            expc(1, 0, 1, 4'h0, 4'h0);
        end
        cyc(1, 1, 1, 0, 4'd0, 4'd8, 0, 0);
        cyc(1, 1, 0, 0, 4'd0, 4'd7, 0, 0);
        cyc(1, 1, 0, 0, 4'd0, 4'd6, 0, 0);

        // Reset beats load, wrap and saturation
        cyc(0, 1, 1, 1, 4'd3, 4'd0, 0, 0);
        cyc(1, 0, 1, 0, 4'd0, 4'd0, 0, 0);
        cyc(1, 0, 1, 1, 4'd9, 4'd9, 0, 0);
        cyc(0, 1, 1, 0, 4'd0, 4'd0, 0, 0);
        cyc(0, 0, 1, 1, 4'd12, 4'd0, 0, 0);
        cyc(1, 0, 1, 0, 4'd0, 4'd0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
